fib_sched: RTL
==============

FIB_SCHED -- requirements
Module: fib_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one fib datapath.
REQ-002 Parameter INPUT_WIDTH, default 6: width of the Fibonacci index n.
REQ-003 Parameter OUTPUT_WIDTH, default 32: width of the Fibonacci result.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for fib_done per job.
REQ-005 Port clk, input, 1: single clock; all logic rises on posedge clk.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req_valid, input, NUM_REQ: per-requester job request.
REQ-008 Port req_n, input, NUM_REQ x INPUT_WIDTH: per-requester index; held stable while req_valid is high.
REQ-009 Port req_ready, output, NUM_REQ: one-hot job accept.
REQ-010 Port rsp_valid, output, 1: response available.
REQ-011 Port rsp_ready, input, 1: response consumer ready.
REQ-012 Port rsp_id, output, clog2(NUM_REQ): index of the requester that owns the response.
REQ-013 Port rsp_result, output, OUTPUT_WIDTH: captured fib_result.
REQ-014 Port rsp_overflow, output, 1: captured fib_overflow.
REQ-015 Port rsp_timeout, output, 1: the job was aborted on timeout.
REQ-016 Port fib_go, output, 1: start pulse to the datapath.
REQ-017 Port fib_n, output, INPUT_WIDTH: index to the datapath.
REQ-018 Ports fib_result (OUTPUT_WIDTH), fib_overflow (1) and fib_done (1), inputs: datapath outputs.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT_CLR, WAIT_DONE and RESPOND.
REQ-020 In IDLE, if any req_valid bit is set, the block SHALL raise req_ready for exactly one cycle for the round-robin winner, latch its req_n and id, and go to ISSUE.
REQ-021 Round-robin: the search SHALL start at the priority pointer; after a grant to requester k, the pointer SHALL become (k+1) mod NUM_REQ.
REQ-022 ISSUE: fib_go=1 for exactly one cycle, with fib_n equal to the latched n; then go to WAIT_CLR.
REQ-023 fib_n SHALL hold the latched n from ISSUE until RESPOND is left.
REQ-024 WAIT_CLR: wait for fib_done=0 (this discards a stale done from the previous job); then go to WAIT_DONE.
REQ-025 WAIT_DONE: on fib_done=1, capture fib_result and fib_overflow, set rsp_timeout=0, and go to RESPOND.
REQ-026 A timeout counter SHALL clear in ISSUE and increment in WAIT_CLR and WAIT_DONE.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1 with no done, the block SHALL go to RESPOND with rsp_result=0, rsp_overflow=0 and rsp_timeout=1.
REQ-028 RESPOND: rsp_valid=1 and response fields stable until rsp_valid and rsp_ready are both high; then go to IDLE.
REQ-029 rsp_valid SHALL be 0 in every state other than RESPOND.
REQ-030 req_ready SHALL be 0 outside IDLE; requests arriving while busy wait and are not dropped.
REQ-031 A requester deasserting req_valid before its grant SHALL lose no other requester's turn.
REQ-032 Minimum latency from acceptance to rsp_valid SHALL be fib latency + 2 cycles; the block SHALL accept at most one job in flight.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE, pointer=0, timeout counter=0, and every output 0 (req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_timeout, fib_go, fib_n).
REQ-034 Reset mid-job SHALL abandon the job without a response.
REQ-035 After rst_n rises, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-036 Package fib_sched_pkg SHALL hold the state_t enum and the default parameter constants.
REQ-037 The round-robin arbiter SHALL be one sub-module, rr_arbiter, with inputs req/pointer and a one-hot grant output.
REQ-038 The fib datapath SHALL stay outside this block, connected through the fib_* ports.

Verification
REQ-039 Bench datapath: fib (INPUT_WIDTH=6, OUTPUT_WIDTH=32).
REQ-040 Single job: req_valid=0001, n=10 -> one fib_go pulse; rsp_id=0, rsp_result=34, rsp_overflow=0, rsp_timeout=0.
REQ-041 Fairness: all four requesters valid continuously -> grant order 0,1,2,3,0; each rsp_id matches its grant.
REQ-042 Overflow: n=63 -> rsp_overflow=1, rsp_timeout=0.
REQ-043 Timeout: stub datapath with fib_done stuck at 0, TIMEOUT_CYCLES=16 -> rsp_valid exactly 16 cycles after ISSUE, with rsp_timeout=1 and rsp_result=0.
REQ-044 Backpressure: rsp_ready=0 for 20 cycles -> response fields stable, no new req_ready, single handshake when rsp_ready=1.
REQ-045 Reset mid-job: rst_n=0 during WAIT_DONE -> all outputs 0 immediately; the next job (n=5) completes with rsp_result=3.

Source files
------------

// File: rtl/fib_sched_pkg.sv
// Shared types and default sizing for the Fibonacci job scheduler.
package fib_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_DONE,
    RESPOND
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_INPUT_WIDTH    = 6;
  localparam int DEF_OUTPUT_WIDTH   = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/fib_sched_rr_arbiter.sv
// Round-robin arbiter: first requester found scanning upward from pointer, wrapping.
module rr_arbiter
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] pointer,
  output logic [NUM_REQ-1:0]  grant
);

  logic [ID_WIDTH-1:0] idx;
  logic                found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((int'(pointer) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_sched.sv
// Shares one external Fibonacci datapath between NUM_REQ requesters, one job at a time,
// with round-robin arbitration and a per-job timeout.
module fib_sched
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0]   req_n,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [ID_WIDTH-1:0]                   rsp_id,
  output logic [OUTPUT_WIDTH-1:0]               rsp_result,
  output logic                                  rsp_overflow,
  output logic                                  rsp_timeout,
  output logic                                  fib_go,
  output logic [INPUT_WIDTH-1:0]                fib_n,
  input  logic [OUTPUT_WIDTH-1:0]               fib_result,
  input  logic                                  fib_overflow,
  input  logic                                  fib_done
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID      = ID_WIDTH'(NUM_REQ - 1);

  state_t               state;
  logic [ID_WIDTH-1:0]  pointer;
  logic [ID_WIDTH-1:0]  win_id;
  logic [ID_WIDTH-1:0]  next_pointer;
  logic [CNT_WIDTH-1:0] tcount;
  logic [CNT_WIDTH-1:0] tcount_inc;
  logic [NUM_REQ-1:0]   grant;
  logic                 timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_arb (
    .req    (req_valid),
    .pointer(pointer),
    .grant  (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_id = ID_WIDTH'(i);
    end
  end

  assign next_pointer = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
  assign tcount_inc   = tcount + 1'b1;
  // The timeout fires on the edge where the counter reaches its last value.
  assign timeout_hit  = (tcount_inc == TIMEOUT_LAST);

  // IDLE takes two cycles per grant: one to register the one-hot req_ready and latch
  // the job, one with req_ready visible so the handshake completes while still idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pointer      <= '0;
      tcount       <= '0;
      req_ready    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
      fib_go       <= 1'b0;
      fib_n        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            req_ready <= '0;
            fib_go    <= 1'b1;
            tcount    <= '0;
            state     <= ISSUE;
          end else if (|req_valid) begin
            req_ready <= grant;
            rsp_id    <= win_id;
            fib_n     <= req_n[win_id];
            pointer   <= next_pointer;
          end
        end
        ISSUE: begin
          fib_go <= 1'b0;
          tcount <= '0;
          state  <= WAIT_CLR;
        end
        WAIT_CLR: begin
          tcount <= tcount_inc;
          if (timeout_hit) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESPOND;
          end else if (!fib_done) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tcount <= tcount_inc;
          if (fib_done) begin
            rsp_result   <= fib_result;
            rsp_overflow <= fib_overflow;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESPOND;
          end else if (timeout_hit) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
